// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        busy_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory: accepts one word request at a time, answers after LATENCY
// cycles with a one-cycle response pulse, flagging misaligned/out-of-range addresses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               write_reg;
  logic               err_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [31:0]        wdata_reg;
  logic               resp_err_reg;
  logic               resp_load_reg;
  logic [31:0]        ram_rd_reg;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               req_err;
  logic               do_access;

  // Range check uses the full word index so aliased upper bits still raise an error.
  assign req_err   = (bus.req_addr_i[1:0] != 2'b00) ||
                     ({2'b00, bus.req_addr_i[31:2]} >= 32'(DEPTH_WORDS));
  assign do_access = rst_i && (state_reg == WAIT) && (cnt_reg == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      write_reg     <= 1'b0;
      err_reg       <= 1'b0;
      idx_reg       <= '0;
      wdata_reg     <= '0;
      resp_err_reg  <= 1'b0;
      resp_load_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid_i) begin
            write_reg <= bus.req_write_i;
            err_reg   <= req_err;
            idx_reg   <= bus.req_addr_i[IDX_W+1:2];
            wdata_reg <= bus.req_wdata_i;
            cnt_reg   <= CNT_W'(LATENCY - 1);
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            resp_err_reg  <= err_reg;
            resp_load_reg <= !write_reg && !err_reg;
            state_reg     <= RESP;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Array kept free of reset so it maps onto block RAM; the read port only
  // updates on an access, so read data holds until the next response.
  always_ff @(posedge clk_i) begin
    if (do_access) begin
      if (write_reg && !err_reg) begin
        mem[idx_reg] <= wdata_reg;
      end
      ram_rd_reg <= mem[idx_reg];
    end
  end

  assign bus.req_ready_o  = (state_reg == IDLE);
  assign bus.busy_o       = (state_reg != IDLE);
  assign bus.resp_valid_o = (state_reg == RESP);
  assign bus.resp_err_o   = resp_err_reg;
  assign bus.resp_rdata_o = resp_load_reg ? ram_rd_reg : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (LATENCY 3 and 1) share clock and reset;
// expected responses are queued at acceptance and matched on each response pulse.
module tb_dmem_responder;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t        q3[$];
  exp_t        q1[$];
  logic [31:0] model3 [int];
  logic [31:0] model1 [int];

  dmem_responder_if if3 ();
  dmem_responder_if if1 ();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (if3.slave)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (if1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic calc_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
  endfunction

  function automatic logic ready_of(input int sel);
    return (sel == 3) ? if3.req_ready_o : if1.req_ready_o;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    if (sel == 3) begin
      if3.req_valid_i = v; if3.req_write_i = w; if3.req_addr_i = a; if3.req_wdata_i = d;
    end else begin
      if1.req_valid_i = v; if1.req_write_i = w; if1.req_addr_i = a; if1.req_wdata_i = d;
    end
  endtask

  // Called while the DUT is idle and about to accept on the next edge.
  task automatic push_exp(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   idx;
    e.err   = calc_err(a);
    e.rdata = 32'h0;
    idx     = int'(a[9:2]);
    if (sel == 3) begin
      e.cyc = cyc + 1 + 3;
      if (!e.err) begin
        if (w) model3[idx] = d;
        else if (model3.exists(idx)) e.rdata = model3[idx];
      end
      q3.push_back(e);
    end else begin
      e.cyc = cyc + 1 + 1;
      if (!e.err) begin
        if (w) model1[idx] = d;
        else if (model1.exists(idx)) e.rdata = model1[idx];
      end
      q1.push_back(e);
    end
    $display("req  dut%0d edge=%0d %s addr=0x%08h wdata=0x%08h exp_rdata=0x%08h exp_err=%0b",
             sel, cyc + 1, w ? "ST" : "LD", a, d, e.rdata, e.err);
  endtask

  task automatic drive(input int sel, input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit exp_resp, output bit acc, output int acc_edge);
    @(negedge clk);
    set_in(sel, v, w, a, d);
    #1;
    acc      = 1'b0;
    acc_edge = cyc + 1;
    if (rst_n && v && ready_of(sel)) begin
      acc = 1'b1;
      if (exp_resp) push_exp(sel, w, a, d);
    end
  endtask

  task automatic req(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input bit exp_resp, output int acc_edge);
    bit acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) drive(sel, 1'b1, w, a, d, exp_resp, acc, acc_edge);
    check("req_accepted", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    set_in(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wait_idle(input int sel);
    bit r = 1'b0;
    for (int i = 0; i < 20 && !r; i++) begin
      @(negedge clk);
      #1;
      r = ready_of(sel);
    end
    check("wait_idle", 32'(r), 32'd1);
  endtask

  // Response monitors: every pulse must match the oldest queued expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (if3.resp_valid_o) begin
      if (q3.size() == 0) begin
        check("d3_resp_queued", 32'(q3.size()), 32'd1);
      end else begin
        e = q3.pop_front();
        $display("resp dut3 cyc=%0d rdata=0x%08h err=%0b", cyc, if3.resp_rdata_o, if3.resp_err_o);
        check("d3_rdata", if3.resp_rdata_o, e.rdata);
        check("d3_err", 32'(if3.resp_err_o), 32'(e.err));
        check("d3_resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (q3.size() != 0 && q3[0].cyc <= cyc) begin
      e = q3.pop_front();
      check("d3_resp_valid", 32'(if3.resp_valid_o), 32'd1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.resp_valid_o) begin
      if (q1.size() == 0) begin
        check("d1_resp_queued", 32'(q1.size()), 32'd1);
      end else begin
        e = q1.pop_front();
        $display("resp dut1 cyc=%0d rdata=0x%08h err=%0b", cyc, if1.resp_rdata_o, if1.resp_err_o);
        check("d1_rdata", if1.resp_rdata_o, e.rdata);
        check("d1_err", 32'(if1.resp_err_o), 32'(e.err));
        check("d1_resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front();
      check("d1_resp_valid", 32'(if1.resp_valid_o), 32'd1);
    end
  end

  initial begin
    int e0, e1, n_acc;
    int edges[3];
    bit acc;

    set_in(3, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset held for two edges with a request pending: nothing may be accepted.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(if3.req_ready_o), 32'd1);
    check("rst_busy", 32'(if3.busy_o), 32'd0);
    check("rst_resp_valid", 32'(if3.resp_valid_o), 32'd0);
    check("rst_resp_err", 32'(if3.resp_err_o), 32'd0);
    check("rst_resp_rdata", if3.resp_rdata_o, 32'h0);

    // Release: the held store is accepted on the first edge with reset high.
    rst_n = 1'b1;
    e0 = cyc + 1;
    push_exp(3, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    check("accept_on_release", 32'(if3.busy_o), 32'd1);
    @(posedge clk);
    #1;
    set_in(3, 1'b0, 1'b0, 32'h0, 32'h0);

    req(3, 1'b0, 32'h0000_0010, 32'h0, 1'b1, e1);
    check("store_load_spacing", 32'(e1 - e0), 32'd5);

    // Misaligned store must not disturb the stored word.
    req(3, 1'b1, 32'h0000_0012, 32'h1111_1111, 1'b1, e1);
    req(3, 1'b0, 32'h0000_0010, 32'h0, 1'b1, e1);

    // Range boundary and aliasing through dropped upper bits.
    req(3, 1'b0, 32'h0000_0400, 32'h0, 1'b1, e1);
    req(3, 1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 1'b1, e1);
    req(3, 1'b0, 32'h0000_03FC, 32'h0, 1'b1, e1);
    req(3, 1'b0, 32'h0001_0010, 32'h0, 1'b1, e1);

    // Reset two edges after accepting a store: aborted, no response, old data kept.
    req(3, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, e1);
    wait_idle(3);
    req(3, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, e1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_busy", 32'(if3.busy_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_resp_valid", 32'(if3.resp_valid_o), 32'd0);
    repeat (4) @(negedge clk);
    req(3, 1'b0, 32'h0000_0020, 32'h0, 1'b1, e1);

    // Request held valid while the address changes every cycle.
    for (int i = 0; i < 11; i++) req(3, 1'b1, 32'h100 + 32'(4 * i), 32'h0000_1000 + 32'(i), 1'b1, e1);
    wait_idle(3);
    n_acc = 0;
    for (int c = 0; c < 11; c++) begin
      drive(3, 1'b1, 1'b0, 32'h100 + 32'(4 * c), 32'h0, 1'b1, acc, e1);
      if (acc) begin
        if (n_acc < 3) edges[n_acc] = e1;
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    set_in(3, 1'b0, 1'b0, 32'h0, 32'h0);
    check("busy_ignore_accepts", 32'(n_acc), 32'd3);
    if (n_acc >= 3) begin
      check("busy_ignore_gap1", 32'(edges[1] - edges[0]), 32'd5);
      check("busy_ignore_gap2", 32'(edges[2] - edges[0]), 32'd10);
    end

    // LATENCY=1: continuous valid accepts every third edge.
    n_acc = 0;
    for (int c = 0; c < 7; c++) begin
      drive(1, 1'b1, (c < 6), (c < 3 || c == 6) ? 32'h8 : 32'hC, 32'h1000_0000 + 32'(c), 1'b1, acc, e1);
      if (acc) begin
        if (n_acc < 3) edges[n_acc] = e1;
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("lat1_accepts", 32'(n_acc), 32'd3);
    if (n_acc >= 3) begin
      check("lat1_gap1", 32'(edges[1] - edges[0]), 32'd3);
      check("lat1_gap2", 32'(edges[2] - edges[0]), 32'd6);
    end
    req(1, 1'b0, 32'h0000_000C, 32'h0, 1'b1, e1);

    for (int i = 0; i < 20 && (q3.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("d3_drain", 32'(q3.size()), 32'd0);
    check("d1_drain", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the memory-side end of the CPU's load/store interface. Accepts one word request at a time from the MEM stage over a valid/ready handshake and models a fixed access latency. Returns read data or a write acknowledge as a one-cycle response pulse, and flags misaligned or out-of-range addresses. It replaces the single-cycle data memory when the pipeline is built with stall-on-memory support.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words stored; power of two, ≥ 4.
- `LATENCY`, default 3: cycles from request acceptance to response; integer ≥ 1.

- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  1  CPU presents a request.
- `req_ready_o`  out  1  responder can accept a request this cycle.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data.
- `resp_valid_o`  out  1  one-cycle response pulse.
- `resp_rdata_o`  out  32  load data; 0 for stores and errors.
- `resp_err_o`  out  1  qualifies `resp_valid_o`: request was misaligned or out of range.
- `busy_o`  out  1  a request is outstanding; drives the pipeline stall.

## Operation
- The FSM has three states:
  - IDLE: `req_ready_o`=1.
  - WAIT: down-counter `cnt` of width clog2(LATENCY) (minimum 1 bit).
  - RESP: `resp_valid_o`=1.
- Combinational outputs:
  - `req_ready_o` = (state==IDLE).
  - `busy_o` = (state!=IDLE).
  - `resp_valid_o` = (state==RESP).
- Acceptance happens on an edge where `req_valid_i`=1 and state is IDLE:
  - Latch write, address and wdata.
  - Compute err = (addr[1:0]!=0) | (addr[31:2] ≥ DEPTH_WORDS).
  - Go to WAIT with `cnt`=LATENCY-1.
- In WAIT with `cnt`≠0: decrement `cnt`.
- In WAIT with `cnt`=0, the next edge goes to RESP and performs the access:
  - Store, no err: mem[addr[clog2(DEPTH)+1:2]] ← wdata. `resp_rdata_o` ← 0.
  - Load, no err: `resp_rdata_o` ← mem[index].
  - err: no memory write. `resp_rdata_o` ← 0, `resp_err_o` ← 1.
- From RESP: the next edge unconditionally returns to IDLE. There is no response backpressure; the CPU must sample the pulse.
- While not in IDLE, request inputs are ignored, including any changes to them.
- Response registers (`resp_rdata_o`, `resp_err_o`) hold their values until the next RESP entry. They are meaningful only while `resp_valid_o`=1.
- Memory array is not cleared by reset.

## Timing
- Reset: on an edge with `rst_i`=0, state←IDLE, `cnt`←0, `resp_rdata_o`←0, `resp_err_o`←0, latched request←0.
- Output values after that reset edge: `req_ready_o`=1, `busy_o`=0, `resp_valid_o`=0.
- Reset mid-operation aborts the outstanding request:
  - A pending store is not committed.
  - No response is issued.
- Latency: request accepted at edge k gives `resp_valid_o`=1 for exactly the cycle between edges k+LATENCY and k+LATENCY+1.
- The earliest next acceptance is edge k+LATENCY+2. Minimum request spacing is LATENCY+2 cycles.
- `busy_o` is high from after edge k until after edge k+LATENCY+1, i.e. LATENCY+1 cycles.
- Store at edge k is visible to a load accepted at edge k+LATENCY+2 or later.
- Out-of-range is checked on the full word index, so an address that aliases into range through dropped upper bits is still an error.

## Test plan
- Reset behaviour: hold `rst_i`=0 for 2 cycles with `req_valid_i`=1 → `req_ready_o`=1, `busy_o`=0, `resp_valid_o`=0, `resp_err_o`=0, and no request is accepted while reset is low. Release reset → request accepted on the first edge with `rst_i`=1.
- Store then load, LATENCY=3: store 0xDEADBEEF to 0x0000_0010 accepted at edge 0 → `resp_valid_o` high in cycle 3–4 with rdata=0 and err=0. Load from 0x10 accepted at edge 5 → `resp_valid_o` in cycle 8–9 with rdata=0xDEADBEEF.
- Misaligned store to 0x0000_0012 → err=1, rdata=0. A subsequent load of 0x10 still returns the prior value.
- Out of range with DEPTH_WORDS=256: load from 0x0000_0400 → err=1, rdata=0. Load from 0x0000_03FC → err=0.
- Busy ignore: hold `req_valid_i`=1 continuously and change the address each cycle → accepts only at edges 0, 5, 10 (LATENCY=3). Each response matches the address present at its acceptance edge.
- Reset mid-operation: store 0x12345678 to 0x20, assert reset at edge 2 → no `resp_valid_o`, `busy_o`=0. A later load of 0x20 returns the old contents, not 0x12345678.
- LATENCY=1 sweep: response is in the cycle after the acceptance edge plus one; spacing is 3 cycles.
